// File: rtl/pci_target_burst_if.sv
// rtl/pci_target_burst_if.sv - PCI target handshake/control signals shared with the master
interface pci_target_burst_if;
  logic       Frame;
  logic       IRDY;
  logic [3:0] Ctrl;
  logic       DevSel;
  logic       TRDY;
  logic       Stop;

  modport master (output Frame, IRDY, Ctrl, input DevSel, TRDY, Stop);
  modport slave  (input Frame, IRDY, Ctrl, output DevSel, TRDY, Stop);
endinterface

// File: rtl/pci_target_burst.sv
// rtl/pci_target_burst.sv - PCI target register file with byte-lane writes,
// selectable DEVSEL timing and a Stop disconnect after MAX_BURST transfers.
module pci_target_burst #(
  parameter logic [31:0] BASE_ADDR  = 32'h00001F40,
  parameter int          DEPTH      = 4,
  parameter int          MAX_BURST  = 4,
  parameter int          DEVSEL_DLY = 0,
  parameter bit          MEM_EN     = 1'b0
) (
  input  logic                 Clk,
  input  logic                 Rst,
  pci_target_burst_if.slave    bus,
  inout  wire  [31:0]          Ad
);

  localparam int IW = (DEPTH > 2) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {IDLE, DECODE, TURN, DATA, STOPPING, IGNORE} state_t;

  state_t          state_q, state_d;
  logic            frame_q;
  logic [IW-1:0]   idx_q, idx_d, idx_nxt;
  logic [7:0]      cnt_q, cnt_d;
  logic [1:0]      dly_q, dly_d;
  logic            rd_q, rd_d;
  logic            devsel_q, devsel_d;
  logic            trdy_q, trdy_d;
  logic            stop_q, stop_d;
  logic            ad_oe, ad_oe_d;
  logic [31:0]     ad_out, ad_out_d;
  logic            we;
  logic [31:0]     mem [DEPTH];

  logic [31:0]     offset;
  logic            addr_hit, cmd_hit, xfer, bus_idle;

  assign Ad         = ad_oe ? ad_out : 'z;
  assign bus.DevSel = devsel_q;
  assign bus.TRDY   = trdy_q;
  assign bus.Stop   = stop_q;

  assign offset   = Ad - BASE_ADDR;
  assign addr_hit = offset < 32'(DEPTH);
  assign cmd_hit  = (bus.Ctrl == 4'b0010) || (bus.Ctrl == 4'b0011) ||
                    (MEM_EN && ((bus.Ctrl == 4'b0110) || (bus.Ctrl == 4'b0111)));
  assign xfer     = (state_q == DATA) && !bus.IRDY && !trdy_q;
  assign bus_idle = bus.Frame && bus.IRDY;
  assign idx_nxt  = idx_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    idx_d    = idx_q;
    cnt_d    = cnt_q;
    dly_d    = dly_q;
    rd_d     = rd_q;
    devsel_d = devsel_q;
    trdy_d   = trdy_q;
    stop_d   = stop_q;
    ad_oe_d  = ad_oe;
    ad_out_d = ad_out;
    we       = 1'b0;
    case (state_q)
      IDLE: begin
        if (!bus.Frame && frame_q) begin
          if (addr_hit && cmd_hit) begin
            state_d = DECODE;
            idx_d   = offset[IW-1:0];
            rd_d    = !bus.Ctrl[0];
            cnt_d   = '0;
            dly_d   = 2'(DEVSEL_DLY);
          end else begin
            state_d = IGNORE;
          end
        end
      end
      DECODE: begin
        if (bus_idle) begin
          state_d = IDLE;
        end else if (dly_q != 2'd0) begin
          dly_d = dly_q - 2'd1;
        end else begin
          devsel_d = 1'b0;
          if (rd_q) begin
            // read data goes out with DevSel; TRDY waits for the turnaround cycle
            ad_oe_d  = 1'b1;
            ad_out_d = mem[idx_q];
            state_d  = TURN;
          end else begin
            trdy_d  = 1'b0;
            state_d = DATA;
          end
        end
      end
      TURN: begin
        if (bus_idle) begin
          devsel_d = 1'b1;
          ad_oe_d  = 1'b0;
          state_d  = IDLE;
        end else begin
          trdy_d  = 1'b0;
          state_d = DATA;
        end
      end
      DATA: begin
        if (xfer) begin
          we       = !rd_q;
          idx_d    = idx_nxt;
          cnt_d    = cnt_q + 8'd1;
          ad_out_d = mem[idx_nxt];
          if (bus.Frame) begin
            devsel_d = 1'b1;
            trdy_d   = 1'b1;
            ad_oe_d  = 1'b0;
            state_d  = IDLE;
          end else if (cnt_q + 8'd1 == 8'(MAX_BURST)) begin
            trdy_d  = 1'b0 | 1'b1;
            stop_d  = 1'b0;
            state_d = STOPPING;
          end
        end else if (bus_idle) begin
          devsel_d = 1'b1;
          trdy_d   = 1'b1;
          ad_oe_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      STOPPING: begin
        if (bus.Frame) begin
          devsel_d = 1'b1;
          trdy_d   = 1'b1;
          stop_d   = 1'b1;
          ad_oe_d  = 1'b0;
          state_d  = IDLE;
        end
      end
      IGNORE: begin
        if (bus_idle) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    frame_q <= bus.Frame;
    if (Rst) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      cnt_q    <= '0;
      dly_q    <= '0;
      rd_q     <= 1'b0;
      devsel_q <= 1'b1;
      trdy_q   <= 1'b1;
      stop_q   <= 1'b1;
      ad_oe    <= 1'b0;
      ad_out   <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      cnt_q    <= cnt_d;
      dly_q    <= dly_d;
      rd_q     <= rd_d;
      devsel_q <= devsel_d;
      trdy_q   <= trdy_d;
      stop_q   <= stop_d;
      ad_oe    <= ad_oe_d;
      ad_out   <= ad_out_d;
      // active-low byte enables: disabled lanes keep their old contents
      if (we) begin
        for (int b = 0; b < 4; b++) begin
          if (!bus.Ctrl[b]) mem[idx_q][8*b +: 8] <= Ad[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_pci_target_burst.sv
// tb/tb_pci_target_burst.sv - directed bench for pci_target_burst
module tb_pci_target_burst;
  logic        Clk = 1'b0;
  logic        Rst = 1'b1;
  logic [31:0] tb_ad = '0, ad2 = '0;
  logic        tb_oe = 1'b0, oe2 = 1'b0;
  wire  [31:0] Ad, Ad2;
  int          compared = 0, mismatched = 0;

  pci_target_burst_if bus ();
  pci_target_burst_if bus2 ();

  assign Ad  = tb_oe ? tb_ad : 'z;
  assign Ad2 = oe2 ? ad2 : 'z;

  pci_target_burst dut (.Clk(Clk), .Rst(Rst), .bus(bus), .Ad(Ad));
  pci_target_burst #(.DEVSEL_DLY(2), .MEM_EN(1'b1)) dut2 (.Clk(Clk), .Rst(Rst), .bus(bus2), .Ad(Ad2));

  always #5 Clk = ~Clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic cyc();
    @(posedge Clk);
    #1;
  endtask

  task automatic idle(input int n);
    bus.Frame = 1'b1; bus.IRDY = 1'b1; bus.Ctrl = 4'h0; tb_oe = 1'b0;
    repeat (n) cyc();
  endtask

  task automatic addr_phase(input logic [31:0] a, input logic [3:0] cmd);
    bus.Frame = 1'b0; bus.IRDY = 1'b1; tb_oe = 1'b1; tb_ad = a; bus.Ctrl = cmd;
    cyc();
  endtask

  // one data phase as the master: waits for TRDY (or Stop), then lets the edge complete it
  task automatic xfer(input bit last, output bit stopped, output logic [31:0] rd);
    int n = 0;
    stopped = 1'b0; rd = '0;
    bus.Frame = last; bus.IRDY = 1'b0;
    while (bus.TRDY !== 1'b0 && bus.Stop !== 1'b0 && n < 16) begin
      cyc(); n++;
    end
    compared++;
    if (n >= 16) begin
      mismatched++;
      $display("FAIL xfer_timeout TRDY=%b Stop=%b required TRDY=0 within 16 cycles", bus.TRDY, bus.Stop);
    end else if (bus.Stop === 1'b0) begin
      stopped = 1'b1;
    end else begin
      rd = Ad;
      cyc();
    end
  endtask

  task automatic test_reset();
    idle(0);
    bus2.Frame = 1'b1; bus2.IRDY = 1'b1; bus2.Ctrl = 4'h0;
    Rst = 1'b1;
    cyc(); cyc();
    Rst = 1'b0;
    compared++;
    if ({bus.DevSel, bus.TRDY, bus.Stop, dut.ad_oe} !== 4'b1110) begin
      mismatched++;
      $display("FAIL reset_outputs got %b required 1110", {bus.DevSel, bus.TRDY, bus.Stop, dut.ad_oe});
    end
    idle(2);
  endtask

  task automatic test_disconnect();
    logic [31:0] d [4] = '{32'h0A0B0C0D, 32'h1A1B1C1D, 32'h2A2B2C2D, 32'h3A3B3C3D};
    bit st; logic [31:0] rd;
    addr_phase(32'h00001F40, 4'b0011);
    for (int i = 0; i < 4; i++) begin
      tb_ad = d[i]; bus.Ctrl = 4'b0000;
      xfer(1'b0, st, rd);
      compared++;
      if (st !== 1'b0) begin
        mismatched++;
        $display("FAIL disc_early_stop beat %0d got stop required no stop", i);
      end
    end
    compared++;
    if ({bus.DevSel, bus.TRDY, bus.Stop} !== 3'b010) begin
      mismatched++;
      $display("FAIL disc_after4 got %b required 010", {bus.DevSel, bus.TRDY, bus.Stop});
    end
    tb_ad = 32'hDEADBEEF;
    xfer(1'b0, st, rd);
    compared++;
    if (st !== 1'b1) begin
      mismatched++;
      $display("FAIL disc_fifth got %b required 1", st);
    end
    cyc(); cyc();
    compared++;
    if ({bus.TRDY, bus.Stop} !== 2'b10) begin
      mismatched++;
      $display("FAIL disc_hold got %b required 10", {bus.TRDY, bus.Stop});
    end
    idle(1);
    compared++;
    if ({bus.DevSel, bus.Stop} !== 2'b11) begin
      mismatched++;
      $display("FAIL disc_release got %b required 11", {bus.DevSel, bus.Stop});
    end
    idle(2);
  endtask

  task automatic test_write_lanes();
    addr_phase(32'h00001F42, 4'b0011);
    compared++;
    if (bus.DevSel !== 1'b1) begin
      mismatched++;
      $display("FAIL wr_devsel_A got %b required 1", bus.DevSel);
    end
    tb_ad = 32'h11111111; bus.Ctrl = 4'b0000; bus.IRDY = 1'b0; bus.Frame = 1'b0;
    cyc();
    compared++;
    if ({bus.DevSel, bus.TRDY} !== 2'b00) begin
      mismatched++;
      $display("FAIL wr_devsel_A1 got %b required 00", {bus.DevSel, bus.TRDY});
    end
    cyc();
    tb_ad = 32'h22222222; bus.Ctrl = 4'b1110; bus.Frame = 1'b1;
    cyc();
    compared++;
    if ({bus.DevSel, bus.TRDY, bus.Stop} !== 3'b111) begin
      mismatched++;
      $display("FAIL wr_complete got %b required 111", {bus.DevSel, bus.TRDY, bus.Stop});
    end
    idle(2);
  endtask

  task automatic test_read_wrap();
    logic [31:0] e [3] = '{32'h3A3B3C22, 32'h0A0B0C0D, 32'h1A1B1C1D};
    bit st; logic [31:0] rd;
    addr_phase(32'h00001F43, 4'b0010);
    tb_oe = 1'b0; bus.Ctrl = 4'h0; bus.IRDY = 1'b0; bus.Frame = 1'b0;
    cyc();
    compared++;
    if ({bus.DevSel, bus.TRDY, dut.ad_oe} !== 3'b011 || Ad !== 32'h3A3B3C22) begin
      mismatched++;
      $display("FAIL rd_A1 got %b/%h required 011/3a3b3c22", {bus.DevSel, bus.TRDY, dut.ad_oe}, Ad);
    end
    cyc();
    compared++;
    if (bus.TRDY !== 1'b0) begin
      mismatched++;
      $display("FAIL rd_trdy_A2 got %b required 0", bus.TRDY);
    end
    for (int i = 0; i < 3; i++) begin
      xfer(i == 2, st, rd);
      compared++;
      if (rd !== e[i]) begin
        mismatched++;
        $display("FAIL rd_wrap beat %0d got %h required %h", i, rd, e[i]);
      end
    end
    compared++;
    if ({bus.DevSel, dut.ad_oe} !== 2'b10) begin
      mismatched++;
      $display("FAIL rd_release got %b required 10", {bus.DevSel, dut.ad_oe});
    end
    idle(2);
  endtask

  task automatic test_wait_state();
    bit st; logic [31:0] rd;
    addr_phase(32'h00001F40, 4'b0010);
    tb_oe = 1'b0; bus.Ctrl = 4'h0;
    xfer(1'b0, st, rd);
    compared++;
    if (rd !== 32'h0A0B0C0D) begin
      mismatched++;
      $display("FAIL ws_first got %h required 0a0b0c0d", rd);
    end
    bus.IRDY = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      compared++;
      if (Ad !== 32'h1A1B1C1D || bus.TRDY !== 1'b0) begin
        mismatched++;
        $display("FAIL ws_hold cycle %0d got %h/%b required 1a1b1c1d/0", i, Ad, bus.TRDY);
      end
    end
    xfer(1'b0, st, rd);
    compared++;
    if (rd !== 32'h1A1B1C1D) begin
      mismatched++;
      $display("FAIL ws_resume got %h required 1a1b1c1d", rd);
    end
    xfer(1'b1, st, rd);
    compared++;
    if (rd !== 32'h11111111) begin
      mismatched++;
      $display("FAIL ws_last got %h required 11111111", rd);
    end
    idle(2);
  endtask

  task automatic test_miss();
    logic [31:0] a [2] = '{32'h00001F44, 32'h00001F40};
    logic [3:0]  c [2] = '{4'b0010, 4'b0110};
    for (int k = 0; k < 2; k++) begin
      addr_phase(a[k], c[k]);
      tb_oe = 1'b0; bus.IRDY = 1'b0;
      for (int i = 0; i < 3; i++) begin
        cyc();
        compared++;
        if ({bus.DevSel, bus.TRDY, bus.Stop, dut.ad_oe} !== 4'b1110) begin
          mismatched++;
          $display("FAIL miss case %0d cycle %0d got %b required 1110", k, i,
                   {bus.DevSel, bus.TRDY, bus.Stop, dut.ad_oe});
        end
      end
      idle(2);
    end
  endtask

  task automatic test_back_to_back();
    bit st; logic [31:0] rd;
    addr_phase(32'h00001F41, 4'b0011);
    tb_ad = 32'h12345678; bus.Ctrl = 4'b0000;
    xfer(1'b1, st, rd);
    addr_phase(32'h00001F41, 4'b0010);
    tb_oe = 1'b0; bus.Ctrl = 4'h0;
    xfer(1'b1, st, rd);
    compared++;
    if (rd !== 32'h12345678) begin
      mismatched++;
      $display("FAIL b2b_read got %h required 12345678", rd);
    end
    idle(2);
  endtask

  task automatic test_slow();
    bus2.Frame = 1'b0; bus2.IRDY = 1'b1; oe2 = 1'b1; ad2 = 32'h00001F41; bus2.Ctrl = 4'b0111;
    cyc();
    ad2 = 32'h5555AAAA; bus2.Ctrl = 4'b0000; bus2.IRDY = 1'b0; bus2.Frame = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      compared++;
      if (bus2.DevSel !== (i < 3) || bus2.TRDY !== (i < 3)) begin
        mismatched++;
        $display("FAIL slow_wr A+%0d got %b%b required %b%b", i, bus2.DevSel, bus2.TRDY, i < 3, i < 3);
      end
    end
    cyc();
    bus2.Frame = 1'b1; bus2.IRDY = 1'b1; oe2 = 1'b0;
    cyc(); cyc();
    bus2.Frame = 1'b0; oe2 = 1'b1; ad2 = 32'h00001F41; bus2.Ctrl = 4'b0110;
    cyc();
    oe2 = 1'b0; bus2.Ctrl = 4'h0; bus2.IRDY = 1'b0; bus2.Frame = 1'b1;
    cyc(); cyc(); cyc();
    compared++;
    if ({bus2.DevSel, bus2.TRDY} !== 2'b01 || Ad2 !== 32'h5555AAAA) begin
      mismatched++;
      $display("FAIL slow_rd A+3 got %b/%h required 01/5555aaaa", {bus2.DevSel, bus2.TRDY}, Ad2);
    end
    cyc();
    compared++;
    if (bus2.TRDY !== 1'b0) begin
      mismatched++;
      $display("FAIL slow_rd_trdy got %b required 0", bus2.TRDY);
    end
    cyc();
    compared++;
    if ({bus2.DevSel, dut2.ad_oe} !== 2'b10) begin
      mismatched++;
      $display("FAIL slow_rd_release got %b required 10", {bus2.DevSel, dut2.ad_oe});
    end
    bus2.IRDY = 1'b1;
    cyc();
  endtask

  task automatic test_reset_midburst();
    bit st; logic [31:0] rd;
    addr_phase(32'h00001F40, 4'b0010);
    tb_oe = 1'b0; bus.Ctrl = 4'h0;
    xfer(1'b0, st, rd);
    xfer(1'b0, st, rd);
    Rst = 1'b1;
    cyc(); cyc();
    compared++;
    if ({bus.DevSel, bus.TRDY, bus.Stop, dut.ad_oe} !== 4'b1110) begin
      mismatched++;
      $display("FAIL midrst_outputs got %b required 1110", {bus.DevSel, bus.TRDY, bus.Stop, dut.ad_oe});
    end
    Rst = 1'b0;
    idle(2);
    addr_phase(32'h00001F40, 4'b0010);
    tb_oe = 1'b0; bus.Ctrl = 4'h0;
    for (int i = 0; i < 4; i++) begin
      xfer(i == 3, st, rd);
      compared++;
      if (rd !== 32'h0) begin
        mismatched++;
        $display("FAIL midrst_word %0d got %h required 00000000", i, rd);
      end
    end
    compared++;
    if ({bus.DevSel, bus.TRDY, bus.Stop} !== 3'b111) begin
      mismatched++;
      $display("FAIL max_burst_with_frame_high got %b required 111", {bus.DevSel, bus.TRDY, bus.Stop});
    end
    idle(2);
  endtask

  initial begin
    test_reset();
    test_disconnect();
    test_write_lanes();
    test_read_wrap();
    test_wait_state();
    test_miss();
    test_back_to_back();
    test_slow();
    test_reset_midburst();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
